// File: rtl/ysyx_22040383_idex.sv
// ID/EX pipeline register for the RV64 core.
// Resolves both source operands through the EX/MEM/WB bypass network,
// selects the ALU operand pair, detects load-use hazards and holds the
// instruction for the execute stage under valid/ready flow control.
module ysyx_22040383_idex #(
   parameter int XLEN  = 64,
   parameter int RADDR = 5
) (
   input  logic             clk,
   input  logic             rst_n,

   // decode slot
   input  logic             id_valid,
   output logic             id_ready,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [RADDR-1:0] id_rs1_addr,
   input  logic [RADDR-1:0] id_rs2_addr,
   input  logic             id_rs1_en,
   input  logic             id_rs2_en,
   input  logic [XLEN-1:0]  id_rs1_data,
   input  logic [XLEN-1:0]  id_rs2_data,
   input  logic [XLEN-1:0]  id_imm,
   input  logic             id_use_pc,
   input  logic             id_use_imm,
   input  logic [RADDR-1:0] id_rd_addr,
   input  logic             id_rd_wen,
   input  logic             id_is_load,
   input  logic [3:0]       id_alu_op,
   input  logic             id_sub,
   input  logic             id_slt_signed,
   input  logic             id_slt_unsigned,
   input  logic             id_word_op,

   // execute feedback
   input  logic [XLEN-1:0]  ex_res,
   input  logic             ex_ready,

   // later-stage bypass sources
   input  logic [RADDR-1:0] mem_rd,
   input  logic             mem_wen,
   input  logic [XLEN-1:0]  mem_data,
   input  logic [RADDR-1:0] wb_rd,
   input  logic             wb_wen,
   input  logic [XLEN-1:0]  wb_data,

   input  logic             flush,

   // held instruction towards the ALU
   output logic             ex_valid,
   output logic [XLEN-1:0]  ex_a,
   output logic [XLEN-1:0]  ex_b,
   output logic [XLEN-1:0]  ex_store_data,
   output logic [3:0]       ex_alu_op,
   output logic             ex_sub,
   output logic             ex_slt_signed,
   output logic             ex_slt_unsigned,
   output logic             ex_word_op,
   output logic [RADDR-1:0] ex_rd_addr,
   output logic             ex_rd_wen,
   output logic             ex_is_load
);

   logic             ex_valid_q,        ex_valid_d;
   logic [XLEN-1:0]  ex_a_q,            ex_a_d;
   logic [XLEN-1:0]  ex_b_q,            ex_b_d;
   logic [XLEN-1:0]  ex_store_data_q,   ex_store_data_d;
   logic [3:0]       ex_alu_op_q,       ex_alu_op_d;
   logic             ex_sub_q,          ex_sub_d;
   logic             ex_slt_signed_q,   ex_slt_signed_d;
   logic             ex_slt_unsigned_q, ex_slt_unsigned_d;
   logic             ex_word_op_q,      ex_word_op_d;
   logic [RADDR-1:0] ex_rd_addr_q,      ex_rd_addr_d;
   logic             ex_rd_wen_q,       ex_rd_wen_d;
   logic             ex_is_load_q,      ex_is_load_d;

   logic [XLEN-1:0]  fwd_rs1;
   logic [XLEN-1:0]  fwd_rs2;
   logic             ex_fwd_ok;
   logic             load_use;
   logic             slot_free;
   logic             fire;

   // A load in EX has no result yet, so it can never be an EX bypass source;
   // that case is handled as a load-use stall instead.
   assign ex_fwd_ok = ex_valid_q && ex_rd_wen_q && !ex_is_load_q;

   // Nearest producer wins: EX, then MEM, then WB, else register file.
   always_comb begin
      fwd_rs1 = id_rs1_data;
      if (id_rs1_en && (id_rs1_addr != '0)) begin
         if (ex_fwd_ok && (ex_rd_addr_q == id_rs1_addr)) begin
            fwd_rs1 = ex_res;
         end else if (mem_wen && (mem_rd == id_rs1_addr)) begin
            fwd_rs1 = mem_data;
         end else if (wb_wen && (wb_rd == id_rs1_addr)) begin
            fwd_rs1 = wb_data;
         end
      end
   end

   // Same bypass priority for the second source.
   always_comb begin
      fwd_rs2 = id_rs2_data;
      if (id_rs2_en && (id_rs2_addr != '0)) begin
         if (ex_fwd_ok && (ex_rd_addr_q == id_rs2_addr)) begin
            fwd_rs2 = ex_res;
         end else if (mem_wen && (mem_rd == id_rs2_addr)) begin
            fwd_rs2 = mem_data;
         end else if (wb_wen && (wb_rd == id_rs2_addr)) begin
            fwd_rs2 = wb_data;
         end
      end
   end

   // Hazard detection and decode-slot handshake.
   always_comb begin
      load_use = 1'b0;
      if (ex_valid_q && ex_is_load_q && ex_rd_wen_q && (ex_rd_addr_q != '0)) begin
         load_use = (id_rs1_en && (id_rs1_addr == ex_rd_addr_q)) ||
                    (id_rs2_en && (id_rs2_addr == ex_rd_addr_q));
      end
      slot_free = !ex_valid_q || ex_ready;
      id_ready  = slot_free && !load_use && !flush;
      fire      = id_valid && id_ready;
   end

   // Next-state for the held instruction: flush kills, a free slot takes the
   // decode slot or a bubble, otherwise everything holds for the consumer.
   always_comb begin
      ex_valid_d        = ex_valid_q;
      ex_a_d            = ex_a_q;
      ex_b_d            = ex_b_q;
      ex_store_data_d   = ex_store_data_q;
      ex_alu_op_d       = ex_alu_op_q;
      ex_sub_d          = ex_sub_q;
      ex_slt_signed_d   = ex_slt_signed_q;
      ex_slt_unsigned_d = ex_slt_unsigned_q;
      ex_word_op_d      = ex_word_op_q;
      ex_rd_addr_d      = ex_rd_addr_q;
      ex_rd_wen_d       = ex_rd_wen_q;
      ex_is_load_d      = ex_is_load_q;

      if (flush) begin
         ex_valid_d   = 1'b0;
         ex_rd_wen_d  = 1'b0;
         ex_is_load_d = 1'b0;
      end else if (slot_free) begin
         ex_valid_d = fire;
         if (fire) begin
            ex_a_d            = id_use_pc  ? id_pc  : fwd_rs1;
            ex_b_d            = id_use_imm ? id_imm : fwd_rs2;
            ex_store_data_d   = fwd_rs2;
            ex_alu_op_d       = id_alu_op;
            ex_sub_d          = id_sub;
            ex_slt_signed_d   = id_slt_signed;
            ex_slt_unsigned_d = id_slt_unsigned;
            ex_word_op_d      = id_word_op;
            ex_rd_addr_d      = id_rd_addr;
            ex_rd_wen_d       = id_rd_wen;
            ex_is_load_d      = id_is_load;
         end else begin
            // Bubble: drop the write/load flags so no stale hazard matches.
            ex_rd_wen_d  = 1'b0;
            ex_is_load_d = 1'b0;
         end
      end
   end

   // Stage register with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q        <= 1'b0;
         ex_a_q            <= '0;
         ex_b_q            <= '0;
         ex_store_data_q   <= '0;
         ex_alu_op_q       <= '0;
         ex_sub_q          <= 1'b0;
         ex_slt_signed_q   <= 1'b0;
         ex_slt_unsigned_q <= 1'b0;
         ex_word_op_q      <= 1'b0;
         ex_rd_addr_q      <= '0;
         ex_rd_wen_q       <= 1'b0;
         ex_is_load_q      <= 1'b0;
      end else begin
         ex_valid_q        <= ex_valid_d;
         ex_a_q            <= ex_a_d;
         ex_b_q            <= ex_b_d;
         ex_store_data_q   <= ex_store_data_d;
         ex_alu_op_q       <= ex_alu_op_d;
         ex_sub_q          <= ex_sub_d;
         ex_slt_signed_q   <= ex_slt_signed_d;
         ex_slt_unsigned_q <= ex_slt_unsigned_d;
         ex_word_op_q      <= ex_word_op_d;
         ex_rd_addr_q      <= ex_rd_addr_d;
         ex_rd_wen_q       <= ex_rd_wen_d;
         ex_is_load_q      <= ex_is_load_d;
      end
   end

   assign ex_valid        = ex_valid_q;
   assign ex_a            = ex_a_q;
   assign ex_b            = ex_b_q;
   assign ex_store_data   = ex_store_data_q;
   assign ex_alu_op       = ex_alu_op_q;
   assign ex_sub          = ex_sub_q;
   assign ex_slt_signed   = ex_slt_signed_q;
   assign ex_slt_unsigned = ex_slt_unsigned_q;
   assign ex_word_op      = ex_word_op_q;
   assign ex_rd_addr      = ex_rd_addr_q;
   assign ex_rd_wen       = ex_rd_wen_q;
   assign ex_is_load      = ex_is_load_q;

endmodule

// File: tb/tb_ysyx_22040383_idex.sv
// Bench for the ID/EX stage: directed scenarios with literal expectations,
// a per-cycle reference model of the held instruction, and a short
// pseudo-random sweep over small register numbers to provoke collisions.
module tb_ysyx_22040383_idex;

   logic        clk;
   logic        rst_n;
   logic        id_valid;
   logic        id_ready;
   logic [63:0] id_pc;
   logic [4:0]  id_rs1_addr, id_rs2_addr;
   logic        id_rs1_en, id_rs2_en;
   logic [63:0] id_rs1_data, id_rs2_data;
   logic [63:0] id_imm;
   logic        id_use_pc, id_use_imm;
   logic [4:0]  id_rd_addr;
   logic        id_rd_wen, id_is_load;
   logic [3:0]  id_alu_op;
   logic        id_sub, id_slt_signed, id_slt_unsigned, id_word_op;
   logic [63:0] ex_res;
   logic        ex_ready;
   logic [4:0]  mem_rd;
   logic        mem_wen;
   logic [63:0] mem_data;
   logic [4:0]  wb_rd;
   logic        wb_wen;
   logic [63:0] wb_data;
   logic        flush;
   logic        ex_valid;
   logic [63:0] ex_a, ex_b, ex_store_data;
   logic [3:0]  ex_alu_op;
   logic        ex_sub, ex_slt_signed, ex_slt_unsigned, ex_word_op;
   logic [4:0]  ex_rd_addr;
   logic        ex_rd_wen, ex_is_load;

   int checks = 0;
   int errors = 0;

   ysyx_22040383_idex #(.XLEN(64), .RADDR(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_use_pc(id_use_pc), .id_use_imm(id_use_imm),
      .id_rd_addr(id_rd_addr), .id_rd_wen(id_rd_wen), .id_is_load(id_is_load),
      .id_alu_op(id_alu_op), .id_sub(id_sub), .id_slt_signed(id_slt_signed),
      .id_slt_unsigned(id_slt_unsigned), .id_word_op(id_word_op),
      .ex_res(ex_res), .ex_ready(ex_ready),
      .mem_rd(mem_rd), .mem_wen(mem_wen), .mem_data(mem_data),
      .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data),
      .flush(flush),
      .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
      .ex_alu_op(ex_alu_op), .ex_sub(ex_sub), .ex_slt_signed(ex_slt_signed),
      .ex_slt_unsigned(ex_slt_unsigned), .ex_word_op(ex_word_op),
      .ex_rd_addr(ex_rd_addr), .ex_rd_wen(ex_rd_wen), .ex_is_load(ex_is_load)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference picture of the instruction the stage should be holding.
   typedef struct packed {
      logic        v;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] sd;
      logic [3:0]  op;
      logic        sub;
      logic        ss;
      logic        su;
      logic        wo;
      logic [4:0]  rd;
      logic        wen;
      logic        ld;
   } held_t;

   held_t m;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Value an instruction reading `addr` must see, from the pipeline picture.
   function automatic logic [63:0] src_val(input logic [4:0] addr, input logic en,
                                           input logic [63:0] rf);
      if (!en || addr == 5'd0) return rf;
      if (m.v && m.wen && !m.ld && m.rd == addr) return ex_res;
      if (mem_wen && mem_rd == addr) return mem_data;
      if (wb_wen && wb_rd == addr) return wb_data;
      return rf;
   endfunction

   function automatic logic model_ready();
      logic hazard;
      hazard = m.v && m.ld && m.wen && (m.rd != 5'd0) &&
               ((id_rs1_en && id_rs1_addr == m.rd) || (id_rs2_en && id_rs2_addr == m.rd));
      return (!m.v || ex_ready) && !hazard && !flush;
   endfunction

   // Advance the model each clock and compare every registered output.
   always @(posedge clk or negedge rst_n) begin
      held_t n;
      if (!rst_n) begin
         m = '0;
      end else begin
         n = m;
         if (flush) begin
            n.v = 1'b0; n.wen = 1'b0; n.ld = 1'b0;
         end else if (!m.v || ex_ready) begin
            if (id_valid && model_ready()) begin
               n.v   = 1'b1;
               n.a   = id_use_pc  ? id_pc  : src_val(id_rs1_addr, id_rs1_en, id_rs1_data);
               n.b   = id_use_imm ? id_imm : src_val(id_rs2_addr, id_rs2_en, id_rs2_data);
               n.sd  = src_val(id_rs2_addr, id_rs2_en, id_rs2_data);
               n.op  = id_alu_op;
               n.sub = id_sub;
               n.ss  = id_slt_signed;
               n.su  = id_slt_unsigned;
               n.wo  = id_word_op;
               n.rd  = id_rd_addr;
               n.wen = id_rd_wen;
               n.ld  = id_is_load;
            end else begin
               n.v = 1'b0; n.wen = 1'b0; n.ld = 1'b0;
            end
         end
         m = n;
         #1;
         chk("m_valid", {63'd0, ex_valid}, {63'd0, m.v});
         chk("m_rd_wen", {63'd0, ex_rd_wen}, {63'd0, m.wen});
         chk("m_is_load", {63'd0, ex_is_load}, {63'd0, m.ld});
         if (m.v) begin
            chk("m_a", ex_a, m.a);
            chk("m_b", ex_b, m.b);
            chk("m_store", ex_store_data, m.sd);
            chk("m_ctl", {52'd0, ex_alu_op, ex_sub, ex_slt_signed, ex_slt_unsigned,
                          ex_word_op, ex_rd_addr},
                         {52'd0, m.op, m.sub, m.ss, m.su, m.wo, m.rd});
         end
      end
   end

   task automatic idle();
      id_valid = 0; id_pc = 0; id_rs1_addr = 0; id_rs2_addr = 0;
      id_rs1_en = 0; id_rs2_en = 0; id_rs1_data = 0; id_rs2_data = 0;
      id_imm = 0; id_use_pc = 0; id_use_imm = 0; id_rd_addr = 0;
      id_rd_wen = 0; id_is_load = 0; id_alu_op = 0; id_sub = 0;
      id_slt_signed = 0; id_slt_unsigned = 0; id_word_op = 0;
      ex_res = 0; ex_ready = 1; mem_rd = 0; mem_wen = 0; mem_data = 0;
      wb_rd = 0; wb_wen = 0; wb_data = 0; flush = 0;
   endtask

   task automatic chk_ready(input string name, input logic exp);
      #1;
      chk(name, {63'd0, id_ready}, {63'd0, exp});
      chk("m_id_ready", {63'd0, id_ready}, {63'd0, model_ready()});
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      repeat (2) @(negedge clk);
      chk("rst_valid", {63'd0, ex_valid}, 64'd0);
      chk("rst_a", ex_a, 64'd0);
      rst_n = 1'b1;
      chk_ready("rst_release_ready", 1'b1);

      // EX bypass beats MEM
      @(negedge clk);
      idle(); id_valid = 1; id_pc = 64'h1000; id_rd_addr = 5; id_rd_wen = 1;
      id_alu_op = 4'd1; id_rs1_addr = 1; id_rs1_en = 1; id_rs1_data = 3;
      chk_ready("prod_ready", 1'b1);
      @(negedge clk);
      chk("prod_rd", {59'd0, ex_rd_addr}, 64'd5);
      idle(); id_valid = 1; ex_res = 64'h10;
      id_rs1_addr = 5; id_rs1_en = 1; id_rs1_data = 64'h99;
      mem_wen = 1; mem_rd = 5; mem_data = 64'h20; id_rd_addr = 6; id_rd_wen = 1;
      chk_ready("cons_ready", 1'b1);
      @(negedge clk);
      chk("ex_bypass_a", ex_a, 64'h10);

      // x0 never bypassed
      idle(); id_valid = 1; id_rs2_addr = 0; id_rs2_en = 1; id_rs2_data = 0;
      wb_wen = 1; wb_rd = 0; wb_data = 64'hFF; id_rd_addr = 8; id_rd_wen = 1;
      @(negedge clk);
      chk("x0_b", ex_b, 64'd0);

      // MEM beats WB
      idle(); id_valid = 1; id_rs1_addr = 9; id_rs1_en = 1; id_rs1_data = 1;
      mem_wen = 1; mem_rd = 9; mem_data = 64'hA; wb_wen = 1; wb_rd = 9; wb_data = 64'hB;
      @(negedge clk);
      chk("mem_over_wb_a", ex_a, 64'hA);

      // WB bypass; disabled source keeps register-file data
      idle(); id_valid = 1; id_rs1_addr = 11; id_rs1_en = 1; id_rs1_data = 2;
      id_rs2_addr = 11; id_rs2_en = 0; id_rs2_data = 64'h77;
      wb_wen = 1; wb_rd = 11; wb_data = 64'hB; mem_wen = 1; mem_rd = 12; mem_data = 64'hC;
      @(negedge clk);
      chk("wb_a", ex_a, 64'hB);
      chk("en0_b", ex_b, 64'h77);

      // Load-use: one bubble, then consumer takes MEM data
      idle(); id_valid = 1; id_rd_addr = 7; id_rd_wen = 1; id_is_load = 1;
      @(negedge clk);
      chk("ld_held", {63'd0, ex_is_load}, 64'd1);
      idle(); id_valid = 1; id_rs2_addr = 7; id_rs2_en = 1; id_rs2_data = 64'h55;
      id_rd_addr = 12; id_rd_wen = 1;
      chk_ready("lu_ready", 1'b0);
      @(negedge clk);
      chk("lu_bubble", {63'd0, ex_valid}, 64'd0);
      mem_wen = 1; mem_rd = 7; mem_data = 64'h1234;
      chk_ready("lu_after_ready", 1'b1);
      @(negedge clk);
      chk("lu_valid", {63'd0, ex_valid}, 64'd1);
      chk("lu_b", ex_b, 64'h1234);

      // Back-pressure for three cycles
      idle(); id_valid = 1; id_pc = 64'h100; id_use_pc = 1; id_imm = 64'h8;
      id_use_imm = 1; id_rd_addr = 13; id_rd_wen = 1;
      @(negedge clk);
      chk("bp_first_a", ex_a, 64'h100);
      idle(); id_valid = 1; ex_ready = 0; id_pc = 64'h200; id_use_pc = 1;
      id_imm = 64'h10; id_use_imm = 1; id_rd_addr = 14; id_rd_wen = 1;
      for (int i = 0; i < 3; i++) begin
         chk_ready("bp_ready", 1'b0);
         @(negedge clk);
         chk("bp_hold_a", ex_a, 64'h100);
         chk("bp_hold_b", ex_b, 64'h8);
         chk("bp_hold_v", {63'd0, ex_valid}, 64'd1);
      end
      ex_ready = 1;
      chk_ready("bp_release_ready", 1'b1);
      @(negedge clk);
      chk("bp_next_a", ex_a, 64'h200);
      chk("bp_next_b", ex_b, 64'h10);

      // Flush kills held and incoming
      idle(); id_valid = 1; flush = 1; id_pc = 64'h300; id_use_pc = 1;
      id_rd_addr = 15; id_rd_wen = 1;
      chk_ready("flush_ready", 1'b0);
      @(negedge clk);
      chk("flush_valid", {63'd0, ex_valid}, 64'd0);
      chk("flush_wen", {63'd0, ex_rd_wen}, 64'd0);
      flush = 0;
      chk_ready("post_flush_ready", 1'b1);
      @(negedge clk);
      chk("post_flush_valid", {63'd0, ex_valid}, 64'd1);
      chk("post_flush_a", ex_a, 64'h300);

      // Asynchronous reset while holding a valid instruction
      idle(); id_valid = 1; ex_ready = 0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", {63'd0, ex_valid}, 64'd0);
      chk("arst_data", ex_a | ex_b | ex_store_data, 64'd0);
      chk("arst_ctl", {52'd0, ex_alu_op, ex_sub, ex_slt_signed, ex_slt_unsigned,
                       ex_word_op, ex_rd_addr, ex_rd_wen, ex_is_load}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      chk_ready("arst_release_ready", 1'b1);

      // Pseudo-random sweep against the model
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         id_valid        = ($urandom_range(0, 3) != 0);
         id_pc           = {$urandom, $urandom};
         id_rs1_addr     = 5'($urandom_range(0, 3));
         id_rs2_addr     = 5'($urandom_range(0, 3));
         id_rs1_en       = $urandom_range(0, 1) == 1;
         id_rs2_en       = $urandom_range(0, 1) == 1;
         id_rs1_data     = {$urandom, $urandom};
         id_rs2_data     = {$urandom, $urandom};
         id_imm          = {$urandom, $urandom};
         id_use_pc       = $urandom_range(0, 3) == 0;
         id_use_imm      = $urandom_range(0, 2) == 0;
         id_rd_addr      = 5'($urandom_range(0, 3));
         id_rd_wen       = $urandom_range(0, 3) != 0;
         id_is_load      = $urandom_range(0, 2) == 0;
         id_alu_op       = 4'($urandom_range(0, 15));
         id_sub          = $urandom_range(0, 1) == 1;
         id_slt_signed   = $urandom_range(0, 1) == 1;
         id_slt_unsigned = $urandom_range(0, 1) == 1;
         id_word_op      = $urandom_range(0, 1) == 1;
         ex_res          = {$urandom, $urandom};
         ex_ready        = $urandom_range(0, 3) != 0;
         mem_rd          = 5'($urandom_range(0, 3));
         mem_wen         = $urandom_range(0, 1) == 1;
         mem_data        = {$urandom, $urandom};
         wb_rd           = 5'($urandom_range(0, 3));
         wb_wen          = $urandom_range(0, 1) == 1;
         wb_data         = {$urandom, $urandom};
         flush           = $urandom_range(0, 9) == 0;
         #1;
         chk("m_id_ready", {63'd0, id_ready}, {63'd0, model_ready()});
      end

      @(negedge clk);
      idle();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_22040383_idex.md
Name: ysyx_22040383_idex

Overview:
- ID/EX pipeline stage of the RV64 five-stage core. Directly upstream of, and feeding, the execute ALU.
- Resolves operands, with bypass from EX, MEM and WB, then registers the operand pair and the ALU control bits.
- Detects load-use hazards and inserts bubbles.
- Handles branch flush and valid/ready back-pressure.

Parameters:
- XLEN, 64, datapath width
- RADDR, 5, register address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds an instruction
- id_ready  out  1  stage accepts decode slot this cycle
- id_pc  in  XLEN  instruction PC
- id_rs1_addr, id_rs2_addr  in  RADDR  source registers
- id_rs1_en, id_rs2_en  in  1  source register actually read
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_use_pc  in  1  operand A = pc
- id_use_imm  in  1  operand B = imm
- id_rd_addr  in  RADDR  destination register
- id_rd_wen  in  1  writes rd
- id_is_load  in  1  instruction is a load
- id_alu_op  in  4  ALU operation
- id_sub, id_slt_signed, id_slt_unsigned, id_word_op  in  1 each  ALU modifiers
- ex_res  in  XLEN  current EX-stage result of the held instruction (fed back)
- ex_ready  in  1  downstream consumes held instruction
- mem_rd  in  RADDR;  mem_wen  in  1;  mem_data  in  XLEN  MEM-stage bypass source
- wb_rd  in  RADDR;  wb_wen  in  1;  wb_data  in  XLEN  WB-stage bypass source
- flush  in  1  branch/trap redirect: kill held and incoming instruction
- ex_valid  out  1  held instruction valid
- ex_a, ex_b  out  XLEN  ALU operands
- ex_store_data  out  XLEN  forwarded rs2 value
- ex_alu_op  out  4;  ex_sub, ex_slt_signed, ex_slt_unsigned, ex_word_op  out  1 each
- ex_rd_addr  out  RADDR;  ex_rd_wen  out  1;  ex_is_load  out  1

Behaviour:
- Reset (rst_n=0, async): every output register is cleared to 0, including ex_valid. id_ready becomes 1 once reset is released. Reset mid-stall drops the held instruction.
- Bypass, per source s in {rs1, rs2}, with addr!=0 and en=1; the first match in this order wins:
  1. EX: ex_valid && ex_rd_wen && !ex_is_load && ex_rd_addr==addr → ex_res
  2. MEM: mem_wen && mem_rd==addr → mem_data
  3. WB: wb_wen && wb_rd==addr → wb_data
  4. Otherwise id_rsX_data.
- addr==0 is never bypassed and always yields id_rsX_data.
- Operand selection:
  - A = id_use_pc ? id_pc : fwd_rs1
  - B = id_use_imm ? id_imm : fwd_rs2
  - store_data = fwd_rs2
- Load-use hazard: load_use = ex_valid && ex_is_load && ex_rd_wen && ex_rd_addr!=0 && ((id_rs1_en && id_rs1_addr==ex_rd_addr) || (id_rs2_en && id_rs2_addr==ex_rd_addr)).
- Handshake:
  - slot_free = !ex_valid || ex_ready
  - id_ready = slot_free && !load_use && !flush (combinational)
  - fire = id_valid && id_ready
- Register update at posedge clk, in priority order:
  1. flush: ex_valid<=0. Incoming instruction is not accepted, since id_ready=0.
  2. Else if slot_free: ex_valid<=fire; payload registers load only on fire. A load-use cycle therefore inserts exactly one bubble (ex_valid=0), and the consumer enters the cycle after.
  3. Else (ex_ready=0, held valid): all outputs hold unchanged.
- Payload registers need not clear on bubble/flush; consumers qualify with ex_valid. ex_rd_wen and ex_is_load are cleared with ex_valid so no stale hazard match occurs.
- Latency: 1 cycle from fire to ex_valid. Throughput: 1 instruction/cycle absent hazards.

Test Plan:
- Reset: assert rst_n=0 mid-operation with ex_valid=1 → all outputs 0 asynchronously; id_ready=1 after release.
- EX bypass: producer add x5 held, ex_res=0x10; consumer rs1=x5, rs1_en=1, id_rs1_data=0x99, mem_wen=1, mem_rd=5, mem_data=0x20 → ex_a=0x10 next cycle (EX beats MEM).
- x0: rs2=0, wb_wen=1, wb_rd=0, wb_data=0xFF, id_rs2_data=0, use_imm=0 → ex_b=0.
- Load-use: ld x7 held (ex_is_load=1), consumer rs2=x7 → id_ready=0 for one cycle, ex_valid=0 bubble; next cycle consumer fires and takes mem_data=0x1234 for ex_b.
- Back-pressure: ex_ready=0 for 3 cycles with id_valid=1 → id_ready=0; ex_a/ex_b/ex_valid stable; fire on the 4th cycle.
- Flush with id_valid=1 and ex_valid=1 → id_ready=0; next cycle ex_valid=0, ex_rd_wen=0; the instruction following flush fires normally.
